q2_i2c_target: RTL and testbench
================================

Name: q2_i2c_target

Overview:
Clocked I2C target (slave) that sits on the two-wire bus the Q2 CPU bit-bangs through its I/O port. It consumes the SCL/SDA levels produced by the CPU-side I2C port and acknowledges transfers. It answers its 7-bit address, holds a small register file with an auto-incrementing pointer, and drives SDA low for ACK and read data. It gives the CPU a real device to talk to, in simulation and on hardware.

Parameters:
ADDR, 7'h50, 7-bit bus address this target answers.
AW, 4, register pointer width; the register file holds 2**AW bytes.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  reset rst, synchronous, active-high.
scl_in  input  1  raw SCL bus level (asynchronous).
sda_in  input  1  raw SDA bus level (asynchronous).
sda_pull  output  1  1 = pull SDA low (open-drain); 0 = release.
wr_strobe  output  1  one-cycle pulse when a data byte is written into the register file.
wr_addr  output  AW  register index of the write reported by wr_strobe.
wr_data  output  8  byte reported by wr_strobe.
busy  output  1  1 from an addressed START until STOP or address mismatch.

Behaviour:
- Synchronise scl_in and sda_in through two flops each, plus one history flop. Edge and condition detection acts on the synchronised values, so latency from a pin edge to the internal event is 3 clk.
- Bus timing requirement: SCL high and low phases each last at least 4 clk. SDA changes only while SCL is low, except for START and STOP.
- START: sync SDA falls while sync SCL is high, in any state including mid-byte. Go to ADDR, clear the bit counter, release sda_pull. A repeated START is handled the same way and keeps the pointer.
- STOP: sync SDA rises while sync SCL is high. Go to IDLE, release sda_pull, clear busy. The pointer is kept.
- Data bits: shifted in MSB-first on the sync SCL rising edge. sda_pull changes only on the sync SCL falling edge, in the same cycle the edge is detected.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: after the 8th rising edge, compare bits [7:1] with ADDR.
  - Match: go to ADDR_ACK and assert busy. On the next falling edge set sda_pull=1. On the falling edge after that, release it.
  - Mismatch: go to IGNORE (no ACK), which exits only on START or STOP.
- Address ACK, then next state:
  - R/W bit 0: go to PTR.
  - R/W bit 1: go to RDATA. On the falling edge that ends the ACK, drive sda_pull = ~reg[ptr][7].
- PTR: the 8th bit loads ptr with byte[AW-1:0]; upper bits are ignored. The byte is always ACKed (PTR_ACK). Then go to WDATA.
- WDATA: on the 8th rising edge:
  - Write reg[ptr] and pulse wr_strobe for 1 clk with wr_addr=ptr and wr_data=byte.
  - Increment ptr modulo 2**AW (wraps from 2**AW-1 to 0).
  - ACK in WDATA_ACK, then return to WDATA for further bytes.
- RDATA: on each falling edge drive the next bit as ~bit, MSB-first. After the 8th bit, release SDA for the master's ACK and go to RDATA_ACK. On the RDATA_ACK rising edge, sample SDA:
  - Low (ACK): increment ptr with wrap and continue in RDATA with the new byte.
  - High (NACK): go to IGNORE; ptr is still incremented.
- A START or STOP detected in the same cycle as an SCL edge takes priority over the edge.
- Reset values:
  - state=IDLE, sda_pull=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, bit counter=0.
  - Register file contents are cleared to 0.
- Reset asserted mid-transfer: all outputs return to reset values on the next clk edge. The target ignores the bus until the next START.
- sda_pull never asserts in IDLE or IGNORE.

Test Plan:
1. Write with ADDR=0x50: START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all four bytes; wr_strobe pulses with (3,0x5A) then (4,0xC3); busy falls after STOP.
2. Read-back: START, 0xA0, 0x03, repeated START, 0xA1, master reads 2 bytes (ACK then NACK), STOP -> SDA carries 0x5A then 0xC3; sda_pull is 0 in both master-ACK slots.
3. Wrong address: START, 0xA2, 0x00, STOP -> sda_pull stays 0 throughout, no wr_strobe, busy stays 0.
4. Pointer wrap: START, 0xA0, 0x0F, 0x11, 0x22, STOP -> writes (15,0x11) then (0,0x22); a subsequent read starting at 0x0F returns 0x11, 0x22.
5. Abort: START, 0xA0, 4 bits of 0x05, then STOP -> no pointer load, no write, state IDLE. Next START, 0xA0 is ACKed normally.
6. Reset mid-read: assert rst for 1 clk while sda_pull=1 during RDATA -> sda_pull=0 and busy=0 the next cycle; register contents read as 0 afterwards.

Source files
------------

// File: rtl/q2_i2c_target.sv
// q2_i2c_target: clocked I2C target with a 2**AW byte register file and an
// auto-incrementing pointer. Bus pins are sampled through a 2-flop
// synchroniser plus a history flop; START/STOP/edges come from those.
module q2_i2c_target #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int         AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_pull,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  logic [1:0]    scl_sync_q, sda_sync_q;
  logic          scl_hist_q, sda_hist_q;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          pull_q, pull_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          wstb_q, wstb_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    mem_q [2**AW];
  logic          mem_we;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in, rd_byte;

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign start_c  = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_c   = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign byte_in  = {shift_q[6:0], sda_s};
  assign rd_byte  = mem_q[ptr_q];

  // Synchronise the bus pins; reset to the idle-high bus level so no false edge appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      pull_q  <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      wstb_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      pull_q  <= pull_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      wstb_q  <= wstb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Register file, cleared on reset, written at the end of each WDATA byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= byte_in;
    end
  end

  // Next state: START/STOP win over SCL edges. In ACK states cnt marks
  // whether the ACK pull has been asserted yet; in RDATA it counts rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    pull_d  = pull_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    wstb_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;
    if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      pull_d  = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (byte_in[7:1] == ADDR) begin
              state_d = S_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = byte_in[0];
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_PTR: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            ptr_d   = byte_in[AW-1:0];
            state_d = S_PTR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            mem_we  = 1'b1;
            wstb_d  = 1'b1;
            waddr_d = ptr_q;
            wdata_d = byte_in;
            ptr_d   = ptr_q + 1'b1;
            state_d = S_WDATA_ACK;
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            pull_d = 1'b1;
            cnt_d  = 4'd1;
          end else begin
            cnt_d  = '0;
            pull_d = 1'b0;
            if (state_q == S_ADDR_ACK) begin
              if (rw_q) begin
                state_d = S_RDATA;
                pull_d  = ~rd_byte[7];
              end else begin
                state_d = S_PTR;
              end
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              pull_d  = 1'b0;
              cnt_d   = '0;
              state_d = S_RDATA_ACK;
            end else begin
              pull_d = ~rd_byte[~cnt_q[2:0]];
            end
          end
        end
        S_RDATA_ACK: if (scl_rise) begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = '0;
          state_d = sda_s ? S_IGNORE : S_RDATA;
        end
        default: ;
      endcase
    end
  end

  assign sda_pull  = pull_q;
  assign busy      = busy_q;
  assign wr_strobe = wstb_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;

endmodule

// File: tb/tb_q2_i2c_target.sv
// Bench for q2_i2c_target: bit-level I2C master driving an open-drain bus,
// a table of bus operations with expected results, and a write scoreboard.
module tb_q2_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_pull, wr_strobe, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int errors = 0;

  assign sda_bus = sda_m & ~sda_pull;

  q2_i2c_target #(.ADDR(7'h50), .AW(4)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_pull(sda_pull), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_BUSY} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [7:0] expv;
    logic       mnack;
    logic       wr;
    logic [3:0] waddr;
  } vec_t;
  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];

  function automatic vec_t mk(op_e op, logic [7:0] d = 8'h0, logic [7:0] e = 8'h0,
                              logic n = 1'b0, logic w = 1'b0, logic [3:0] a = 4'h0);
    vec_t v;
    v.op = op; v.data = d; v.expv = e; v.mnack = n; v.wr = w; v.waddr = a;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: SDA set mid-low, sampled mid-high.
  task automatic clk_bit(input logic v, output logic s, output logic p);
    wclk(4); sda_m = v;
    wclk(4); scl_m = 1'b1;
    wclk(4); s = sda_bus; p = sda_pull;
    wclk(4); scl_m = 1'b0;
  endtask

  task automatic start_c();
    if (!scl_m) begin
      wclk(4); sda_m = 1'b1;
      wclk(4); scl_m = 1'b1;
      wclk(8);
    end
    sda_m = 1'b0;
    wclk(8); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wclk(4); sda_m = 1'b0;
    wclk(4); scl_m = 1'b1;
    wclk(8); sda_m = 1'b1;
    wclk(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, p;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s, p);
    clk_bit(1'b1, s, p);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b, output logic p);
    logic s, pp;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s, pp);
      b = {b[6:0], s};
    end
    clk_bit(nack, s, p);
  endtask

  task automatic run_vecs();
    logic       ack, p;
    logic [7:0] b;
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_START: start_c();
        OP_STOP:  stop_c();
        OP_WR: begin
          if (vecs[i].wr) exp_q.push_back('{a: vecs[i].waddr, d: vecs[i].data});
          write_byte(vecs[i].data, ack);
          chk($sformatf("v%0d_ack_%0h", i, vecs[i].data), {31'd0, ack}, {31'd0, vecs[i].expv[0]});
        end
        OP_RD: begin
          read_byte(vecs[i].mnack, b, p);
          chk($sformatf("v%0d_rdata", i), {24'd0, b}, {24'd0, vecs[i].expv});
          chk($sformatf("v%0d_mack_pull", i), {31'd0, p}, 32'd0);
        end
        OP_BUSY: chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].expv[0]});
        default: ;
      endcase
    end
    vecs.delete();
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (!rst && wr_strobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr %0d data %0h want no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          errors++;
          $display("FAIL wr_strobe: got (%0d,%0h) want (%0d,%0h)", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  // The target may only pull SDA while it owns an addressed transfer.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (sda_pull && !busy) begin
        errors++;
        $display("FAIL pull_idle: got sda_pull 1 busy 0 want sda_pull 0");
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, s, p;
    wclk(3);
    rst = 1'b0;
    wclk(2);
    chk("rst_pull", {31'd0, sda_pull}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wstb", {31'd0, wr_strobe}, 32'd0);
    chk("rst_waddr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wdata", {24'd0, wr_data}, 32'd0);

    // Write 0x5A, 0xC3 starting at 3.
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h03, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h5A, 8'h1, 1'b0, 1'b1, 4'd3));
    vecs.push_back(mk(OP_WR, 8'hC3, 8'h1, 1'b0, 1'b1, 4'd4));
    vecs.push_back(mk(OP_STOP));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h0));
    // Read back through a repeated START.
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h03, 8'h1));
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA1, 8'h1));
    vecs.push_back(mk(OP_RD, 8'h0, 8'h5A, 1'b0));
    vecs.push_back(mk(OP_RD, 8'h0, 8'hC3, 1'b1));
    vecs.push_back(mk(OP_STOP));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h0));
    // Wrong address: no ACK anywhere, busy stays low.
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA2, 8'h0));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h0));
    vecs.push_back(mk(OP_WR, 8'h00, 8'h0));
    vecs.push_back(mk(OP_STOP));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h0));
    // Pointer wrap 15 -> 0, then read across the wrap.
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h0F, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h11, 8'h1, 1'b0, 1'b1, 4'd15));
    vecs.push_back(mk(OP_WR, 8'h22, 8'h1, 1'b0, 1'b1, 4'd0));
    vecs.push_back(mk(OP_STOP));
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h0F, 8'h1));
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA1, 8'h1));
    vecs.push_back(mk(OP_RD, 8'h0, 8'h11, 1'b0));
    vecs.push_back(mk(OP_RD, 8'h0, 8'h22, 1'b1));
    vecs.push_back(mk(OP_STOP));
    run_vecs();

    // Abort mid pointer byte with STOP, then a clean address phase.
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    run_vecs();
    for (int i = 7; i >= 4; i--) clk_bit(1'(8'h05 >> i), s, p);
    stop_c();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h1));
    vecs.push_back(mk(OP_STOP));
    run_vecs();

    // Reset while the target drives the first read bit (0x5A MSB=0 -> pull).
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h03, 8'h1));
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA1, 8'h1));
    run_vecs();
    wclk(4);
    chk("rd_pull_before_rst", {31'd0, sda_pull}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_pull", {31'd0, sda_pull}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wdata", {24'd0, wr_data}, 32'd0);
    sda_m = 1'b1;
    stop_c();
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA0, 8'h1));
    vecs.push_back(mk(OP_WR, 8'h03, 8'h1));
    vecs.push_back(mk(OP_START));
    vecs.push_back(mk(OP_WR, 8'hA1, 8'h1));
    vecs.push_back(mk(OP_RD, 8'h0, 8'h00, 1'b1));
    vecs.push_back(mk(OP_STOP));
    vecs.push_back(mk(OP_BUSY, 8'h0, 8'h0));
    run_vecs();

    wclk(4);
    chk("wr_queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
